// File: rtl/mmcm_reset_sequencer.sv
// Drives MMCM RST, watches a synchronized LOCKED, and releases a downstream
// reset once lock has held for STABLE_CYCLES; retries on timeout or lock loss.
module mmcm_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             soft_reset,
  output logic             mmcm_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0]    RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {HOLD, WAIT_LOCK, SETTLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync_q;
  logic          locked_s;

  // LOCKED comes from the MMCM's own clock domain; only locked_s is trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], locked};
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      cnt         <= '0;
      mmcm_rst    <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      retry_count <= '0;
      loss_count  <= '0;
    end else if (soft_reset) begin
      // Wins over any same-cycle transition, so a simultaneous loss is not counted.
      state    <= HOLD;
      cnt      <= '0;
      mmcm_rst <= 1'b1;
      sys_rst  <= 1'b1;
      ready    <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == RST_LAST) begin
            state    <= WAIT_LOCK;
            cnt      <= '0;
            mmcm_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            state    <= HOLD;
            cnt      <= '0;
            mmcm_rst <= 1'b1;
            if (retry_count != CNT_MAX) retry_count <= retry_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          // A dropout here is an acquisition glitch: fall back without re-resetting.
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state    <= HOLD;
            cnt      <= '0;
            mmcm_rst <= 1'b1;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
            if (loss_count != CNT_MAX) loss_count <= loss_count + 1'b1;
          end
        end
        default: begin
          state    <= HOLD;
          cnt      <= '0;
          mmcm_rst <= 1'b1;
          sys_rst  <= 1'b1;
          ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule
